// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a framed host byte stream (length, payload, XOR checksum)
// into one-cycle imem write pulses and holds the CPU until the frame checks out.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [7:0]          chk_q, chk_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [15:0]         len_full;
  logic [16:0]         words_after;

  assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
  assign accept   = in_valid && in_ready;

  // Length as it stands once the high byte is accepted, and the word count after the current word.
  assign len_full    = {in_data, len_q[7:0]};
  assign words_after = 17'(word_cnt_q) + 17'd1;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a value unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          len_d      = '0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          chk_d      = '0;
        end
      end

      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end

      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if ((len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d    = S_DATA;
            word_cnt_d = '0;
            byte_idx_d = '0;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word; bytes arrive little-endian.
            we_d       = 1'b1;
            waddr_d    = word_cnt_q[ADDR_W-1:0];
            wdata_d    = {in_data, asm_q};
            word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
            if (words_after == {1'b0, len_q}) state_d = S_CHK;
          end else begin
            asm_d = {in_data, asm_q[23:8]};
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes and status come from a frame-level model.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int                wr_cyc_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                acc_q[$];

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: parse header, build words, compare checksum.
  function automatic void model(input bq_t fr, output bit m_err, output bit m_done,
                                output logic [31:0] words[$]);
    int n;
    logic [7:0] x;
    words = {};
    n = int'(fr[0]) + 256 * int'(fr[1]);
    if (n == 0 || n > 2 ** ADDR_W) begin
      m_err = 1'b1;
      m_done = 1'b0;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      words.push_back({fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]});
      for (int k = 0; k < 4; k++) x = x ^ fr[2+4*w+k];
    end
    m_done = (fr[2+4*n] == x);
    m_err  = !m_done;
  endfunction

  function automatic bq_t mk_good(input logic [7:0] last);
    bq_t q;
    q.push_back(8'h02); q.push_back(8'h00);
    q.push_back(8'hB3); q.push_back(8'h81); q.push_back(8'h20); q.push_back(8'h00);
    q.push_back(8'hB3); q.push_back(8'h82); q.push_back(8'h41); q.push_back(8'h40);
    q.push_back(last);
    return q;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t fr, input int gap_max, input int start_at);
    int t;
    int g;
    for (int i = 0; i < fr.size(); i++) begin
      g = (gap_max > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, gap_max)) : 0;
      repeat (g) begin
        @(negedge clk); in_valid = 1'b0;
      end
      if (i == start_at) begin
        @(negedge clk); in_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fr[i];
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        @(negedge clk); t++;
      end
      check($sformatf("in_ready_byte%0d", i), {31'b0, in_ready}, 32'd1);
      if (in_ready !== 1'b1) begin
        in_valid = 1'b0;
        return;
      end
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t fr, input int gap_max, input int start_at);
    bit m_err, m_done;
    logic [31:0] words[$];
    int nw;
    wr_cyc_q = {}; wr_addr_q = {}; wr_data_q = {}; acc_q = {};
    pulse_start();
    check({name, "_hold_at_start"}, {31'b0, cpu_hold}, 32'd1);
    check({name, "_done_at_start"}, {31'b0, done}, 32'd0);
    check({name, "_err_at_start"}, {31'b0, err}, 32'd0);
    send_bytes(fr, gap_max, start_at);
    repeat (2) @(negedge clk);
    model(fr, m_err, m_done, words);
    check({name, "_nwrites"}, wr_cyc_q.size(), words.size());
    nw = (wr_cyc_q.size() < words.size()) ? wr_cyc_q.size() : words.size();
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s_w%0d_addr", name, i), {24'b0, wr_addr_q[i]}, i);
      check($sformatf("%s_w%0d_data", name, i), wr_data_q[i], words[i]);
      check($sformatf("%s_w%0d_cycle", name, i), wr_cyc_q[i], acc_q[2+4*i+3]);
    end
    if (words.size() > 0) begin
      check({name, "_waddr_hold"}, {24'b0, waddr}, words.size() - 1);
      check({name, "_wdata_hold"}, wdata, words[words.size()-1]);
    end
    check({name, "_done"}, {31'b0, done}, {31'b0, m_done});
    check({name, "_err"}, {31'b0, err}, {31'b0, m_err});
    check({name, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, m_err});
    check({name, "_in_ready_end"}, {31'b0, in_ready}, 32'd0);
    check({name, "_we_end"}, {31'b0, we}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({name, "_we"}, {31'b0, we}, 32'd0);
    check({name, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({name, "_done"}, {31'b0, done}, 32'd0);
    check({name, "_err"}, {31'b0, err}, 32'd0);
    check({name, "_waddr"}, {24'b0, waddr}, 32'd0);
    check({name, "_wdata"}, wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    bq_t fr;
    logic [7:0] x;
    int n;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Directed frames: good, bad checksum, length bounds.
    run_frame("good", mk_good(8'h22), 0, -1);
    check("good_w0_const", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h002081B3);
    check("good_w1_const", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hx, 32'h404182B3);
    run_frame("badchk", mk_good(8'h23), 0, -1);

    fr = {}; fr.push_back(8'h00); fr.push_back(8'h00);
    run_frame("len0", fr, 0, -1);
    fr = {}; fr.push_back(8'h01); fr.push_back(8'h01);
    run_frame("len257", fr, 0, -1);

    // N == 256 is the largest legal length: loader must move on to DATA.
    pulse_start();
    fr = {}; fr.push_back(8'h00); fr.push_back(8'h01);
    send_bytes(fr, 0, -1);
    repeat (2) @(negedge clk);
    check("len256_in_ready", {31'b0, in_ready}, 32'd1);
    check("len256_err", {31'b0, err}, 32'd0);
    check("len256_hold", {31'b0, cpu_hold}, 32'd1);

    // Reset mid-load after 5 accepted bytes, then reload.
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_abort_a");
    @(negedge clk); reset = 1'b0;
    pulse_start();
    fr = mk_good(8'h22);
    fr = fr[0:4];
    send_bytes(fr, 0, -1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk); reset = 1'b0;
    run_frame("after_rst", mk_good(8'h22), 0, -1);

    // Stalls with a start pulse inside DATA.
    for (int r = 0; r < 3; r++)
      run_frame($sformatf("stall%0d", r), mk_good(8'h22), 3, 5 + r);

    // Random frames, mostly good, sometimes corrupted checksum.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      fr = {}; fr.push_back(8'(n)); fr.push_back(8'h00);
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        fr.push_back(8'($urandom));
        x = x ^ fr[fr.size()-1];
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      fr.push_back(x);
      run_frame($sformatf("rand%0d", r), fr, 3, -1);
    end

    // Random out-of-range length.
    n = $urandom_range(257, 65535);
    fr = {}; fr.push_back(8'(n)); fr.push_back(8'(n >> 8));
    run_frame("randlen", fr, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
